// File: rtl/coms_frame_rx.sv
// Status-frame receiver: hunts for the magic word, collects the payload, checks CRC16 and
// motor id, and keeps saturating per-slot ok / CRC-error / timeout statistics.
module coms_frame_rx #(
    parameter int unsigned NUMBER_OF_MOTORS = 8,
    parameter int unsigned PAYLOAD_BYTES    = 22,
    parameter logic [31:0] MAGIC            = 32'h1CEB00DA,
    parameter int unsigned TIMEOUT_CYCLES   = 1400,
    parameter int unsigned CNT_WIDTH        = 16,
    parameter int unsigned SLOT_W           = $clog2(NUMBER_OF_MOTORS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  rx_valid,
    input  logic [7:0]                            rx_data,
    input  logic                                  expect_valid,
    input  logic [7:0]                            expect_id,
    input  logic [SLOT_W-1:0]                     expect_slot,
    output logic                                  busy,
    output logic                                  frame_valid,
    output logic [SLOT_W-1:0]                     frame_slot,
    output logic [PAYLOAD_BYTES*8-1:0]            frame_payload,
    output logic [1:0]                            last_error,
    output logic [NUMBER_OF_MOTORS*CNT_WIDTH-1:0] ok_count,
    output logic [NUMBER_OF_MOTORS*CNT_WIDTH-1:0] crc_err_count,
    output logic [NUMBER_OF_MOTORS*CNT_WIDTH-1:0] timeout_count
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IDX_W   = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int unsigned PW      = PAYLOAD_BYTES * 8;
    localparam int unsigned CW_ALL  = NUMBER_OF_MOTORS * CNT_WIDTH;

    localparam logic [1:0] ErrOk      = 2'd0;
    localparam logic [1:0] ErrTimeout = 2'd1;
    localparam logic [1:0] ErrCrc     = 2'd2;
    localparam logic [1:0] ErrId      = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StHunt,
        StPayload,
        StCrcHi,
        StCrcLo,
        StCheck
    } state_e;

    state_e              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [23:0]         window_q, window_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [15:0]         crc_q, crc_d;
    logic [7:0]          crc_hi_q, crc_hi_d;
    logic [7:0]          crc_lo_q, crc_lo_d;
    logic [PW-1:0]       buf_q, buf_d;
    logic [7:0]          id_q, id_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                frame_valid_q, frame_valid_d;
    logic [SLOT_W-1:0]   frame_slot_q, frame_slot_d;
    logic [PW-1:0]       frame_payload_q, frame_payload_d;
    logic [1:0]          last_error_q, last_error_d;
    logic [CW_ALL-1:0]   ok_q, ok_d;
    logic [CW_ALL-1:0]   crc_err_q, crc_err_d;
    logic [CW_ALL-1:0]   timeout_q, timeout_d;
    logic                active;

    // Poly 0x8005, MSB-first, no reflection.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Saturating increment of one slot; out-of-range slots match nothing.
    function automatic logic [CW_ALL-1:0] bump(input logic [CW_ALL-1:0] cnt,
                                               input logic [SLOT_W-1:0] slot);
        logic [CW_ALL-1:0] r;
        r = cnt;
        for (int s = 0; s < int'(NUMBER_OF_MOTORS); s++) begin
            if (int'(slot) == s && r[s*CNT_WIDTH +: CNT_WIDTH] != '1) begin
                r[s*CNT_WIDTH +: CNT_WIDTH] = r[s*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        window_d        = window_q;
        idx_d           = idx_q;
        crc_d           = crc_q;
        crc_hi_d        = crc_hi_q;
        crc_lo_d        = crc_lo_q;
        buf_d           = buf_q;
        id_d            = id_q;
        slot_d          = slot_q;
        frame_valid_d   = 1'b0;
        frame_slot_d    = frame_slot_q;
        frame_payload_d = frame_payload_q;
        last_error_d    = last_error_q;
        ok_d            = ok_q;
        crc_err_d       = crc_err_q;
        timeout_d       = timeout_q;

        active = (state_q inside {StHunt, StPayload, StCrcHi, StCrcLo});
        if (active) timer_d = timer_q - 1'b1;

        unique case (state_q)
            StIdle: begin
                if (expect_valid) begin
                    id_d     = expect_id;
                    slot_d   = expect_slot;
                    timer_d  = TIMER_W'(TIMEOUT_CYCLES);
                    window_d = '0;
                    state_d  = StHunt;
                end
            end
            StHunt: begin
                if (rx_valid) begin
                    window_d = {window_q[15:0], rx_data};
                    if ({window_q, rx_data} == MAGIC) begin
                        state_d = StPayload;
                        crc_d   = 16'hFFFF;
                        idx_d   = '0;
                    end
                end
            end
            StPayload: begin
                if (rx_valid) begin
                    buf_d[8*(PAYLOAD_BYTES - 1 - 32'(idx_q)) +: 8] = rx_data;
                    crc_d = crc16_byte(crc_q, rx_data);
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_W'(PAYLOAD_BYTES - 1)) state_d = StCrcHi;
                end
            end
            StCrcHi: begin
                if (rx_valid) begin
                    crc_hi_d = rx_data;
                    state_d  = StCrcLo;
                end
            end
            StCrcLo: begin
                if (rx_valid) begin
                    crc_lo_d = rx_data;
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                state_d = StIdle;
                if (crc_q != {crc_hi_q, crc_lo_q}) begin
                    crc_err_d    = bump(crc_err_q, slot_q);
                    last_error_d = ErrCrc;
                end else if (buf_q[PW-1 -: 8] != id_q) begin
                    last_error_d = ErrId;
                end else begin
                    frame_valid_d   = 1'b1;
                    frame_payload_d = buf_q;
                    frame_slot_d    = slot_q;
                    ok_d            = bump(ok_q, slot_q);
                    last_error_d    = ErrOk;
                end
            end
            default: state_d = StIdle;
        endcase

        // A final CRC byte arriving on the expiring cycle still completes the frame.
        if (active && timer_q == TIMER_W'(1) && !(state_q == StCrcLo && rx_valid)) begin
            state_d      = StIdle;
            timeout_d    = bump(timeout_q, slot_q);
            last_error_d = ErrTimeout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            timer_q         <= '0;
            window_q        <= '0;
            idx_q           <= '0;
            crc_q           <= '0;
            crc_hi_q        <= '0;
            crc_lo_q        <= '0;
            buf_q           <= '0;
            id_q            <= '0;
            slot_q          <= '0;
            frame_valid_q   <= 1'b0;
            frame_slot_q    <= '0;
            frame_payload_q <= '0;
            last_error_q    <= '0;
            ok_q            <= '0;
            crc_err_q       <= '0;
            timeout_q       <= '0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            window_q        <= window_d;
            idx_q           <= idx_d;
            crc_q           <= crc_d;
            crc_hi_q        <= crc_hi_d;
            crc_lo_q        <= crc_lo_d;
            buf_q           <= buf_d;
            id_q            <= id_d;
            slot_q          <= slot_d;
            frame_valid_q   <= frame_valid_d;
            frame_slot_q    <= frame_slot_d;
            frame_payload_q <= frame_payload_d;
            last_error_q    <= last_error_d;
            ok_q            <= ok_d;
            crc_err_q       <= crc_err_d;
            timeout_q       <= timeout_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign frame_valid   = frame_valid_q;
    assign frame_slot    = frame_slot_q;
    assign frame_payload = frame_payload_q;
    assign last_error    = last_error_q;
    assign ok_count      = ok_q;
    assign crc_err_count = crc_err_q;
    assign timeout_count = timeout_q;

endmodule
